// File: rtl/inject_arbiter_pkg.sv
// rtl/inject_arbiter_pkg.sv - shared packet type and node-level constants for the injection scheduler
package inject_arbiter_pkg;

    // Width of one network packet as seen at the router input port.
    localparam int PKT_W = 32;

    // Number of local traffic sources per PE node, used by the node wrapper.
    localparam int INJ_REQ = 4;

    typedef logic [PKT_W-1:0] packet_t;

endpackage

// File: rtl/inject_arbiter_if.sv
// rtl/inject_arbiter_if.sv - request/network handshake bundle between local sources, arbiter and router
//
// Signals:
//   req_val    [0:REQ-1]  source i has a packet
//   req_data   [0:REQ-1]  packet of source i
//   req_rdy    [0:REQ-1]  one-hot or zero, source i accepted this cycle
//   i_data                packet to the network
//   i_data_val            i_data is valid
//   net_en                network accepts i_data this cycle
// Modports:
//   master  arbiter side
//   slave   sources + router side
interface inject_arbiter_if #(
    parameter int REQ = 4
);
    import inject_arbiter_pkg::*;

    logic    [0:REQ-1] req_val;
    packet_t [0:REQ-1] req_data;
    logic    [0:REQ-1] req_rdy;
    packet_t           i_data;
    logic              i_data_val;
    logic              net_en;

    modport master (
        input  req_val,
        input  req_data,
        input  net_en,
        output req_rdy,
        output i_data,
        output i_data_val
    );

    modport slave (
        output req_val,
        output req_data,
        output net_en,
        input  req_rdy,
        input  i_data,
        input  i_data_val
    );

endinterface

// File: rtl/inject_arbiter_rr_arbiter.sv
// rtl/inject_arbiter_rr_arbiter.sv - combinational round-robin pick starting at a pointer
//
// Ports:
//   req      [0:N-1]          request vector
//   ptr      [$clog2(N)-1:0]  highest-priority index this cycle
//   gnt      [0:N-1]          one-hot grant, zero when no request
//   gnt_idx  [$clog2(N)-1:0]  encoded grant index, zero when no request
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [0:N-1]           req,
    input  logic [$clog2(N)-1:0]   ptr,
    output logic [0:N-1]           gnt,
    output logic [$clog2(N)-1:0]   gnt_idx
);

    localparam int IDX_W = $clog2(N);

    logic found;
    int   idx;

    // Scan N positions starting at ptr, wrapping past N-1 back to 0;
    // the first asserted request wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int off = 0; off < N; off++) begin
            idx = int'(ptr) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/inject_arbiter.sv
// rtl/inject_arbiter.sv - round-robin injection scheduler with holding register, backpressure and gap
//
// Ports:
//   clk      clock, rising edge
//   reset    asynchronous, active-high
//   bus      inject_arbiter_if.master: requests in, grants out, network output
//   cfg_gap  idle cycles forced after each injection, sampled at transfer
//   cnt_clr  synchronous clear of all injection counters (wins over increment)
//   inj_cnt  saturating per-source injection counters
module inject_arbiter
    import inject_arbiter_pkg::*;
#(
    parameter int REQ   = INJ_REQ,
    parameter int GAP_W = 4,
    parameter int CNT_W = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    inject_arbiter_if.master            bus,
    input  logic [GAP_W-1:0]            cfg_gap,
    input  logic                        cnt_clr,
    output logic [0:REQ-1][CNT_W-1:0]   inj_cnt
);

    localparam int PTR_W = $clog2(REQ);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_HOLD,
        ST_GAP
    } state_t;

    state_t             state;
    state_t             state_n;
    packet_t            hold_data;
    logic [PTR_W-1:0]   hold_tag;
    logic [PTR_W-1:0]   rr_ptr;
    logic [GAP_W-1:0]   gap_cnt;
    logic [GAP_W-1:0]   gap_n;

    logic               transfer;
    logic               load_ok;
    logic               grant;
    logic [0:REQ-1]     gnt;
    logic [PTR_W-1:0]   gnt_idx;

    rr_arbiter #(
        .N (REQ)
    ) u_rr (
        .req     (bus.req_val),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign transfer = (state == ST_HOLD) && bus.net_en;

    // The register may refill in the same cycle it drains only when no gap
    // follows; reset is folded in so no source is released while in reset.
    assign load_ok = !reset && ((state == ST_EMPTY) || (transfer && (cfg_gap == '0)));
    assign grant   = load_ok && (|bus.req_val);

    assign bus.req_rdy    = load_ok ? gnt : '0;
    assign bus.i_data_val = (state == ST_HOLD);
    assign bus.i_data     = hold_data;

    always_comb begin
        state_n = state;
        gap_n   = gap_cnt;
        case (state)
            ST_EMPTY: begin
                if (grant) begin
                    state_n = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (transfer) begin
                    if (cfg_gap != '0) begin
                        state_n = ST_GAP;
                        gap_n   = cfg_gap;
                    end else if (grant) begin
                        state_n = ST_HOLD;
                    end else begin
                        state_n = ST_EMPTY;
                    end
                end
            end
            ST_GAP: begin
                gap_n = gap_cnt - GAP_W'(1);
                if (gap_cnt <= GAP_W'(1)) begin
                    state_n = ST_EMPTY;
                    gap_n   = '0;
                end
            end
            default: begin
                state_n = ST_EMPTY;
                gap_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_EMPTY;
            gap_cnt <= '0;
        end else begin
            state   <= state_n;
            gap_cnt <= gap_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_data <= '0;
            hold_tag  <= '0;
            rr_ptr    <= '0;
        end else if (grant) begin
            hold_data <= bus.req_data[gnt_idx];
            hold_tag  <= gnt_idx;
            rr_ptr    <= (gnt_idx == PTR_W'(REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inj_cnt <= '0;
        end else if (cnt_clr) begin
            inj_cnt <= '0;
        end else if (transfer && (inj_cnt[hold_tag] != '1)) begin
            inj_cnt[hold_tag] <= inj_cnt[hold_tag] + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_inject_arbiter.sv
// tb/tb_inject_arbiter.sv - directed self-checking bench for inject_arbiter
module tb_inject_arbiter;
    import inject_arbiter_pkg::*;

    localparam int REQ   = 4;
    localparam int GAP_W = 4;
    localparam int CNT_W = 4;

    logic                       clk = 1'b0;
    logic                       reset;
    logic [GAP_W-1:0]           cfg_gap;
    logic                       cnt_clr;
    logic [0:REQ-1][CNT_W-1:0]  inj_cnt;
    logic [0:REQ-1][CNT_W-1:0]  cnt_exp;

    int checks   = 0;
    int failures = 0;

    inject_arbiter_if #(.REQ(REQ)) bus ();

    inject_arbiter #(
        .REQ   (REQ),
        .GAP_W (GAP_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.master),
        .cfg_gap (cfg_gap),
        .cnt_clr (cnt_clr),
        .inj_cnt (inj_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [0:REQ-1] oh(input int i);
        logic [0:REQ-1] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    function automatic packet_t pay(input int i);
        return packet_t'(32'hA5A5_0000 + i * 17);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        cfg_gap     = '0;
        cnt_clr     = 1'b0;
        bus.net_en  = 1'b0;
        bus.req_val = 4'b1111;
        for (int i = 0; i < REQ; i++) bus.req_data[i] = pay(i);
        tick;
        tick;

        check("rst_val", 64'(bus.i_data_val), 64'd0);
        check("rst_data", 64'(bus.i_data), 64'd0);
        check("rst_rdy", 64'(bus.req_rdy), 64'd0);
        check("rst_cnt", 64'(inj_cnt), 64'd0);

        // All four sources requesting, no gap, network always ready.
        reset      = 1'b0;
        bus.net_en = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            check("rr_rdy", 64'(bus.req_rdy), 64'(oh(k % 4)));
            if (k == 0) begin
                check("rr_val0", 64'(bus.i_data_val), 64'd0);
            end else begin
                check("rr_val", 64'(bus.i_data_val), 64'd1);
                check("rr_data", 64'(bus.i_data), 64'(pay((k - 1) % 4)));
            end
            tick;
        end
        bus.req_val = '0;
        #1;
        check("rr_last_data", 64'(bus.i_data), 64'(pay(3)));
        check("rr_last_rdy", 64'(bus.req_rdy), 64'd0);
        tick;
        check("rr_idle", 64'(bus.i_data_val), 64'd0);
        cnt_exp = {4'd2, 4'd2, 4'd2, 4'd2};
        check("rr_cnt", 64'(inj_cnt), 64'(cnt_exp));

        // Source 2 alone under backpressure: packet held stable.
        bus.net_en  = 1'b0;
        bus.req_val = oh(2);
        #1;
        check("bp_grant", 64'(bus.req_rdy), 64'(oh(2)));
        tick;
        for (int k = 0; k < 5; k++) begin
            check("bp_val", 64'(bus.i_data_val), 64'd1);
            check("bp_data", 64'(bus.i_data), 64'(pay(2)));
            check("bp_rdy", 64'(bus.req_rdy), 64'd0);
            tick;
        end
        bus.net_en  = 1'b1;
        bus.req_val = '0;
        #1;
        check("bp_xfer_val", 64'(bus.i_data_val), 64'd1);
        tick;
        check("bp_after", 64'(bus.i_data_val), 64'd0);
        cnt_exp = {4'd2, 4'd2, 4'd3, 4'd2};
        check("bp_cnt", 64'(inj_cnt), 64'(cnt_exp));

        // Fairness: after a grant to 3, {0,3} is served 0 then 3.
        bus.req_val = oh(3);
        #1;
        check("ord_g3", 64'(bus.req_rdy), 64'(oh(3)));
        tick;
        bus.req_val = 4'b1001;
        #1;
        check("ord_g0", 64'(bus.req_rdy), 64'(oh(0)));
        check("ord_d3", 64'(bus.i_data), 64'(pay(3)));
        tick;
        check("ord_g3b", 64'(bus.req_rdy), 64'(oh(3)));
        check("ord_d0", 64'(bus.i_data), 64'(pay(0)));
        tick;
        bus.req_val = '0;
        #1;
        check("ord_d3b", 64'(bus.i_data), 64'(pay(3)));
        check("ord_rdy0", 64'(bus.req_rdy), 64'd0);
        tick;
        check("ord_idle", 64'(bus.i_data_val), 64'd0);

        // Wrap-around: grant 2 leaves rr_ptr=3.
        bus.req_val = oh(2);
        #1;
        check("wr_g2a", 64'(bus.req_rdy), 64'(oh(2)));
        tick;
        bus.req_val = '0;
        #1;
        tick;
        check("wr_idle", 64'(bus.i_data_val), 64'd0);
        bus.req_val = oh(2);
        #1;
        check("wr_g2b", 64'(bus.req_rdy), 64'(oh(2)));
        tick;
        bus.req_val = 4'b0110;
        #1;
        check("wr_g1", 64'(bus.req_rdy), 64'(oh(1)));
        tick;
        bus.req_val = '0;
        #1;
        check("wr_d1", 64'(bus.i_data), 64'(pay(1)));
        tick;
        cnt_exp = {4'd3, 4'd3, 4'd5, 4'd4};
        check("wr_cnt", 64'(inj_cnt), 64'(cnt_exp));

        // Gap of 3: one injection every 5 cycles, no grants during the gap.
        cfg_gap     = 4'd3;
        bus.req_val = oh(1);
        #1;
        for (int c = 0; c < 15; c++) begin
            check("gap_val", 64'(bus.i_data_val), (c % 5 == 1) ? 64'd1 : 64'd0);
            check("gap_rdy", 64'(bus.req_rdy), (c % 5 == 0) ? 64'(oh(1)) : 64'd0);
            tick;
        end
        bus.req_val = '0;
        cfg_gap     = '0;
        #1;
        check("gap_end_val", 64'(bus.i_data_val), 64'd0);
        cnt_exp = {4'd3, 4'd6, 4'd5, 4'd4};
        check("gap_cnt", 64'(inj_cnt), 64'(cnt_exp));

        // Saturation: 20 transfers from source 0 into a 4-bit counter.
        bus.req_val = oh(0);
        #1;
        for (int k = 0; k < 20; k++) tick;
        bus.req_val = '0;
        #1;
        tick;
        cnt_exp = {4'd15, 4'd6, 4'd5, 4'd4};
        check("sat_cnt", 64'(inj_cnt), 64'(cnt_exp));

        // Clear coinciding with a transfer: clear wins.
        bus.req_val = oh(0);
        #1;
        tick;
        bus.req_val = '0;
        cnt_clr     = 1'b1;
        #1;
        check("clr_xfer_val", 64'(bus.i_data_val), 64'd1);
        tick;
        cnt_clr = 1'b0;
        check("clr_cnt", 64'(inj_cnt), 64'd0);

        bus.req_val = oh(2);
        #1;
        tick;
        bus.req_val = '0;
        #1;
        tick;
        cnt_exp = {4'd0, 4'd0, 4'd1, 4'd0};
        check("pre_rst_cnt", 64'(inj_cnt), 64'(cnt_exp));

        // Reset while holding a packet.
        bus.net_en  = 1'b0;
        bus.req_val = oh(2);
        #1;
        tick;
        check("hold_val", 64'(bus.i_data_val), 64'd1);
        check("hold_data", 64'(bus.i_data), 64'(pay(2)));
        bus.req_val = '0;
        #1;
        reset = 1'b1;
        #1;
        check("arst_val", 64'(bus.i_data_val), 64'd0);
        check("arst_data", 64'(bus.i_data), 64'd0);
        check("arst_cnt", 64'(inj_cnt), 64'd0);
        tick;
        reset       = 1'b0;
        bus.net_en  = 1'b1;
        bus.req_val = 4'b1111;
        #1;
        check("post_rst_g0", 64'(bus.req_rdy), 64'(oh(0)));
        tick;
        check("post_rst_val", 64'(bus.i_data_val), 64'd1);
        check("post_rst_data", 64'(bus.i_data), 64'(pay(0)));
        bus.req_val = '0;
        #1;
        tick;
        cnt_exp = {4'd1, 4'd0, 4'd0, 4'd0};
        check("post_rst_cnt", 64'(inj_cnt), 64'(cnt_exp));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
